// File: rtl/piece_step_scheduler.sv
// piece_step_scheduler: arbitrates latched piece actions onto one shared collision checker
// and sequences lock, spawn and game-over for the falling piece.
module piece_step_scheduler #(
    parameter logic [3:0] X_ORI = 4'd6,
    parameter logic [4:0] Y_ORI = 5'd23
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  req,
    input  logic [15:0] rot_cw_float,
    input  logic [15:0] rot_ccw_float,
    input  logic [15:0] spawn_float,
    input  logic        chk_ack,
    input  logic        chk_ok,
    input  logic        lock_done,
    output logic [3:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [15:0] float,
    output logic        chk_req,
    output logic [3:0]  chk_x,
    output logic [4:0]  chk_y,
    output logic [15:0] chk_float,
    output logic        lock_req,
    output logic        clear_req,
    output logic        busy,
    output logic        game_over
);
    typedef enum logic [2:0] {OVER, WAIT, CHECK, LOCK, SPAWN} state_t;
    state_t state, state_d;
    logic [6:0]  pend, pend_d, clr;
    logic [2:0]  act, act_d, sel;
    logic [3:0]  pos_x_d, chk_x_d;
    logic [4:0]  pos_y_d, chk_y_d;
    logic [15:0] float_d, chk_float_d;
    logic        chk_req_d, game_over_d, lock_now, at_edge, spawn_load;

    always_comb begin
        sel = pend[3] ? 3'd3 : pend[4] ? 3'd4 : pend[5] ? 3'd5 : pend[6] ? 3'd6 : pend[2] ? 3'd2 : 3'd0;
        at_edge = (sel == 3'd5 && pos_x == 4'd0) || (sel == 3'd6 && pos_x == 4'd15) ||
                  ((sel == 3'd0 || sel == 3'd2) && pos_y == 5'd0);
        // a hard drop that reaches row 0 has nowhere left to go, so it locks like a failure
        lock_now = (act == 3'd2) ? (!chk_ok || chk_y == 5'd0) : (act == 3'd0 && !chk_ok);
        state_d = state;
        act_d = act;
        clr = '0;
        pos_x_d = pos_x;
        pos_y_d = pos_y;
        float_d = float;
        chk_x_d = chk_x;
        chk_y_d = chk_y;
        chk_float_d = chk_float;
        chk_req_d = chk_req;
        game_over_d = game_over;
        case (state)
            WAIT: if (|pend) begin
                act_d = sel;
                if (at_edge) begin
                    clr[sel] = 1'b1;
                    state_d = (sel == 3'd5 || sel == 3'd6) ? WAIT : LOCK;
                end else begin
                    state_d = CHECK;
                    chk_req_d = 1'b1;
                    chk_x_d = (sel == 3'd5) ? pos_x - 4'd1 : (sel == 3'd6) ? pos_x + 4'd1 : pos_x;
                    chk_y_d = (sel == 3'd0 || sel == 3'd2) ? pos_y - 5'd1 : pos_y;
                    chk_float_d = (sel == 3'd3) ? rot_cw_float : (sel == 3'd4) ? rot_ccw_float : float;
                end
            end
            CHECK: if (chk_ack) begin
                if (chk_ok) begin
                    pos_x_d = chk_x;
                    pos_y_d = chk_y;
                    float_d = chk_float;
                end
                if (act == 3'd2 && !lock_now)
                    chk_y_d = chk_y - 5'd1;
                else begin
                    chk_req_d = 1'b0;
                    clr[act] = 1'b1;
                    state_d = lock_now ? LOCK : WAIT;
                end
            end
            LOCK: if (lock_done) state_d = SPAWN;
            SPAWN: if (!chk_req)
                chk_req_d = 1'b1;
            else if (chk_ack) begin
                chk_req_d = 1'b0;
                state_d = chk_ok ? WAIT : OVER;
                game_over_d = !chk_ok;
            end
            default: ;
        endcase
        spawn_load = req[1] || (state == LOCK && lock_done);
        if (req[1]) begin
            state_d = SPAWN;
            chk_req_d = 1'b0;
            game_over_d = 1'b0;
        end
        if (spawn_load) begin
            pos_x_d = X_ORI;
            pos_y_d = Y_ORI;
            float_d = spawn_float;
            chk_x_d = X_ORI;
            chk_y_d = Y_ORI;
            chk_float_d = spawn_float;
        end
        pend_d = ((state_d == LOCK && state != LOCK) ? 7'd0 : pend & ~clr) | (req & 7'b1111101);
        if (req[1] || state_d == OVER) pend_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OVER;
            pend <= '0;
            act <= '0;
            pos_x <= X_ORI;
            pos_y <= Y_ORI;
            float <= '0;
            chk_x <= X_ORI;
            chk_y <= Y_ORI;
            chk_float <= '0;
            chk_req <= 1'b0;
            lock_req <= 1'b0;
            clear_req <= 1'b0;
            busy <= 1'b1;
            game_over <= 1'b1;
        end else begin
            state <= state_d;
            pend <= pend_d;
            act <= act_d;
            pos_x <= pos_x_d;
            pos_y <= pos_y_d;
            float <= float_d;
            chk_x <= chk_x_d;
            chk_y <= chk_y_d;
            chk_float <= chk_float_d;
            chk_req <= chk_req_d;
            lock_req <= state_d == LOCK;
            clear_req <= req[1];
            busy <= state_d != WAIT;
            game_over <= game_over_d;
        end
    end
endmodule

// File: tb/tb_piece_step_scheduler.sv
// tb_piece_step_scheduler: scoreboard bench; an action-level piece model predicts every checker
// handshake and lock, a negedge monitor pops and compares them as the DUT presents them.
module tb_piece_step_scheduler;
    localparam logic [3:0] XO = 4'd6;
    localparam logic [4:0] YO = 5'd23;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [6:0]  req = '0;
    logic [15:0] rot_cw_float, rot_ccw_float, spawn_float = 16'h0660;
    logic        chk_ack = 1'b0, chk_ok = 1'b0, lock_done = 1'b0;
    logic [3:0]  pos_x, chk_x;
    logic [4:0]  pos_y, chk_y;
    logic [15:0] float, chk_float;
    logic        chk_req, lock_req, clear_req, busy, game_over;

    piece_step_scheduler #(.X_ORI(XO), .Y_ORI(YO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .rot_cw_float(rot_cw_float), .rot_ccw_float(rot_ccw_float), .spawn_float(spawn_float),
        .chk_ack(chk_ack), .chk_ok(chk_ok), .lock_done(lock_done),
        .pos_x(pos_x), .pos_y(pos_y), .float(float),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_float(chk_float),
        .lock_req(lock_req), .clear_req(clear_req), .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;
    assign rot_cw_float  = {float[11:0], float[15:12]};
    assign rot_ccw_float = {float[3:0], float[15:4]};

    typedef struct packed {logic lk; logic [3:0] x; logic [4:0] y; logic [15:0] f;} ev_t;
    ev_t exp_q[$];
    int checks = 0, errors = 0;
    int floor_y = 0, xmin = 0, xmax = 15, ack_max = 0, lock_max = 0;
    int ack_wait = 0, lock_wait = 0, late_req = 0, late_done = 0;
    int clear_cnt = 0, restarts = 0;
    bit ack_en = 1'b1;
    logic [3:0]  m_x = XO;
    logic [4:0]  m_y = YO;
    logic [15:0] m_f = '0;
    bit          m_over = 1'b1;

    function automatic bit fits(int x, int y);
        return y >= floor_y && x >= xmin && x <= xmax;
    endfunction

    // checker environment: answers each presented candidate after a random delay
    always @(negedge clk) begin
        chk_ack = 1'b0;
        chk_ok = 1'b0;
        if (late_req != late_done) begin
            chk_ack = 1'b1;
            late_done = late_req;
        end else if (chk_req && ack_en) begin
            if (ack_wait == 0) begin
                chk_ack = 1'b1;
                chk_ok = fits(chk_x, chk_y);
                ack_wait = $urandom_range(0, ack_max);
            end else ack_wait--;
        end
    end

    always @(negedge clk) begin
        lock_done = 1'b0;
        if (lock_req) begin
            if (lock_wait == 0) begin
                lock_done = 1'b1;
                lock_wait = $urandom_range(0, lock_max);
            end else lock_wait--;
        end
    end

    task automatic expect_ev(input bit lk);
        ev_t e;
        logic [24:0] got;
        checks++;
        got = lk ? {pos_x, pos_y, float} : {chk_x, chk_y, chk_float};
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected handshake x=%0d y=%0d f=%h", lk ? "lock" : "check", got[24:21], got[20:16], got[15:0]);
        end else begin
            e = exp_q.pop_front();
            if (e.lk != lk || got != {e.x, e.y, e.f}) begin
                errors++;
                $display("FAIL %s: got lock=%0b x=%0d y=%0d f=%h, expected lock=%0b x=%0d y=%0d f=%h",
                         lk ? "lock" : "check", lk, got[24:21], got[20:16], got[15:0], e.lk, e.x, e.y, e.f);
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (clear_req) clear_cnt++;
            if (chk_req && lock_req) begin
                checks++;
                errors++;
                $display("FAIL overlap: chk_req and lock_req both high");
            end
            if (chk_req && chk_ack) expect_ev(1'b0);
            if (lock_req && lock_done) expect_ev(1'b1);
        end
    end

    function automatic void m_spawn();
        m_x = XO;
        m_y = YO;
        m_f = spawn_float;
        exp_q.push_back({1'b0, XO, YO, spawn_float});
        if (!fits(XO, YO)) m_over = 1'b1;
    endfunction

    function automatic void m_lock();
        exp_q.push_back({1'b1, m_x, m_y, m_f});
        m_spawn();
    endfunction

    // one action; returns 1 when the piece locked, which discards everything still pending
    function automatic bit m_act(int b);
        int nx, ny;
        logic [15:0] nf;
        nx = m_x;
        ny = m_y;
        nf = m_f;
        if (b == 2) begin
            while (m_y > 0) begin
                exp_q.push_back({1'b0, m_x, 5'(m_y - 1), m_f});
                if (!fits(m_x, m_y - 1)) break;
                m_y = 5'(m_y - 1);
            end
            m_lock();
            return 1'b1;
        end
        if ((b == 5 && m_x == 0) || (b == 6 && m_x == 15)) return 1'b0;
        if (b == 0 && m_y == 0) begin
            m_lock();
            return 1'b1;
        end
        if (b == 3) nf = {m_f[11:0], m_f[15:12]};
        if (b == 4) nf = {m_f[3:0], m_f[15:4]};
        if (b == 5) nx = nx - 1;
        if (b == 6) nx = nx + 1;
        if (b == 0) ny = ny - 1;
        exp_q.push_back({1'b0, 4'(nx), 5'(ny), nf});
        if (fits(nx, ny)) begin
            m_x = 4'(nx);
            m_y = 5'(ny);
            m_f = nf;
            return 1'b0;
        end
        if (b == 0) begin
            m_lock();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_mask(logic [6:0] mask);
        int order[6];
        order = '{3, 4, 5, 6, 2, 0};
        if (mask[1]) begin
            restarts++;
            m_over = 1'b0;
            m_spawn();
            return;
        end
        if (m_over) return;
        for (int i = 0; i < 6; i++)
            if (mask[order[i]] && m_act(order[i])) break;
    endfunction

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic settle(input string name);
        int t = 0;
        @(negedge clk);
        while (t < 400 && !(exp_q.size() == 0 && (m_over ? game_over : !busy))) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            errors++;
            $display("FAIL %s: timeout with %0d expected events pending", name, exp_q.size());
            exp_q.delete();
        end
        cmp({name, "_state"}, {pos_x, pos_y, float, game_over}, {m_x, m_y, m_f, m_over});
        cmp({name, "_clears"}, clear_cnt, restarts);
    endtask

    task automatic step(input logic [6:0] mask, input string name);
        m_mask(mask);
        @(negedge clk) req = mask;
        @(negedge clk) req = '0;
        settle(name);
    endtask

    initial begin
        int bits[6];
        logic [6:0] mask;
        int t;
        bits = '{0, 2, 3, 4, 5, 6};
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("reset_state", {pos_x, pos_y, float, game_over, busy}, {XO, YO, 16'h0, 1'b1, 1'b1});
        cmp("reset_handshakes", {chk_req, lock_req, clear_req}, 3'b000);
        cmp("reset_candidate", {chk_x, chk_y, chk_float}, {XO, YO, 16'h0});

        step(7'b0000010, "restart");
        cmp("restart_wait", busy, 1'b0);
        step(7'b0101000, "rot_and_left");
        repeat (5) step(7'b0100000, "left");
        step(7'b0100000, "left_at_0");
        repeat (15) step(7'b1000000, "right");
        step(7'b1000000, "right_at_15");

        floor_y = 17;
        spawn_float = 16'h4E00;
        step(7'b0000100, "hard_drop");

        floor_y = 24;
        step(7'b0000001, "gravity_to_over");
        step(7'b0000001, "over_gravity");
        step(7'b0100000, "over_left");
        floor_y = 0;
        step(7'b0000010, "recover");

        // restart abandons a check whose ack is held back, then a stray ack arrives
        ack_en = 1'b0;
        @(negedge clk) req = 7'b0100000;
        @(negedge clk) req = '0;
        t = 0;
        while (!chk_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        cmp("midcheck_candidate", {chk_req, chk_x}, {1'b1, 4'(m_x - 1)});
        repeat (3) @(negedge clk);
        m_mask(7'b0000010);
        req = 7'b0000010;
        #1 late_req++;
        ack_en = 1'b1;
        @(negedge clk) req = '0;
        cmp("midcheck_abandon", {chk_req, clear_req}, 2'b01);
        settle("restart_midcheck");

        for (int i = 0; i < 60; i++) begin
            spawn_float = 16'($urandom);
            floor_y = ($urandom_range(0, 11) == 0) ? 24 : int'($urandom_range(0, 8));
            xmin = $urandom_range(0, 3);
            xmax = $urandom_range(12, 15);
            ack_max = $urandom_range(0, 3);
            lock_max = $urandom_range(0, 3);
            mask = '0;
            if (m_over || $urandom_range(0, 11) == 0) mask[1] = 1'b1;
            else begin
                mask[bits[$urandom_range(0, 5)]] = 1'b1;
                if ($urandom_range(0, 1) == 1) mask[bits[$urandom_range(0, 5)]] = 1'b1;
            end
            if (mask[1]) floor_y = $urandom_range(0, 8);
            step(mask, "random");
        end

        cmp("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piece_step_scheduler.md
# piece_step_scheduler

Sequences all falling-piece updates through a single shared collision checker. Replaces the chain of parallel checkers with one time-multiplexed checker. Latches one-cycle action requests, arbitrates them by fixed priority and owns the piece position/shape registers. Drives the lock (combine + row-eliminate) stage and the spawn / game-over decision. Sits between the keyboard/gravity pulse generators and the board datapath (checker, combine, eliminator, display).

## Interface
Parameters:
- `X_ORI`, 6: spawn column
- `Y_ORI`, 23: spawn row

Ports:
- `clk`  in  1  system clock; all state on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  7  one-cycle request pulses: [0] gravity, [1] restart, [2] hard drop, [3] rotate cw, [4] rotate ccw, [5] left, [6] right
- `rot_cw_float`, `rot_ccw_float`  in  16  combinational rotations of `float`
- `spawn_float`  in  16  next shape from random source
- `chk_ack`  in  1  checker has evaluated the presented candidate
- `chk_ok`  in  1  candidate collision-free; valid only with `chk_ack`
- `lock_done`  in  1  combine/eliminate finished, static board updated
- `pos_x` / `pos_y` / `float`  out  4 / 5 / 16  committed piece state
- `chk_req`  out  1  candidate presented
- `chk_x` / `chk_y` / `chk_float`  out  4 / 5 / 16  candidate
- `lock_req`  out  1  merge committed piece into board
- `clear_req`  out  1  one-cycle pulse: clear static board
- `busy`  out  1  state ≠ WAIT
- `game_over`  out  1  game halted

## Operation
- Pending register `pend[6:0]`: a set bit stays set until its action completes. When a `req` bit and the clear of the same bit coincide, set wins.
- States: OVER, WAIT, CHECK, LOCK, SPAWN.
- Restart, from any state: next edge goes to SPAWN with `clear_req`=1 for 1 cycle.
  - `pos` ← (`X_ORI`,`Y_ORI`), `float` ← `spawn_float`, `pend` ← 0, `game_over` ← 0.
  - Any open check or lock is abandoned; `chk_req` and `lock_req` drop.
- OVER: all non-restart requests are discarded (`pend[6:0]` except [1] held at 0).
- WAIT: select the highest-priority pending bit, in order restart > cw > ccw > left > right > hard drop > gravity, and enter CHECK with its candidate:
  - rotate: (`pos_x`,`pos_y`,`rot_*_float`)
  - left/right: `pos_x`∓1
  - drop/gravity: `pos_y`−1
- Boundary short-circuit, no check issued, treated as fail:
  - left at `pos_x`=0
  - right at `pos_x`=15
  - drop/gravity at `pos_y`=0
- CHECK: `chk_req`=1, candidate stable until `chk_ack`. On ack:
  - ok: commit candidate into `pos_*`/`float`, clear pend bit, go to WAIT.
  - fail on rotate/left/right: discard, clear bit, go to WAIT.
  - gravity fail: go to LOCK.
  - hard drop ok: present `pos_y`−1 next cycle, staying in CHECK with `chk_req` high.
  - hard drop fail: go to LOCK.
- Entering LOCK clears all non-restart pend bits.
- LOCK: `lock_req`=1 until `lock_done`, then SPAWN.
- SPAWN: `pos` ← origin, `float` ← `spawn_float`, check the spawn candidate.
  - ok: go to WAIT.
  - fail: `game_over`=1, go to OVER.

## Timing
- Reset values:
  - state OVER, `game_over`=1, `pos_x`=`X_ORI`, `pos_y`=`Y_ORI`, `float`=0, `pend`=0
  - `chk_req`=0, `lock_req`=0, `clear_req`=0, `busy`=1
  - `chk_x`/`chk_y`/`chk_float` = `pos`/`float`
- All outputs are registered.
- Request latency:
  - pulse sampled at edge n sets `pend` at n.
  - WAIT arbitrates at n+1; `chk_req` is high from n+1 to n+2.
  - Earliest commit is at the edge where `chk_ack` is sampled high.
- Zero-wait checker (ack tied high): one move takes 2 cycles; a hard drop of k rows takes k+1 checks back-to-back.
- `pos_*`/`float` change only on a commit edge, restart, or SPAWN entry.
- `chk_ok` without `chk_ack` is ignored.
- `lock_done` outside LOCK is ignored.
- `lock_req` and `chk_req` are never high together.
- Subtraction on x/y is never allowed to wrap; the boundary short-circuits above cover all wrap cases.

## Test plan
- Reset, `req[1]` pulse, `spawn_float`=0x0660, ack/ok tied high → `clear_req` pulse 1 cycle, `pos`=(6,23), `float`=0x0660, `game_over`=0, back in WAIT.
- In WAIT, `req[5]` and `req[3]` in the same cycle with ok=1 → rotation commits first, then `pos_x` 6→5; both pend bits cleared.
- `pos_x`=0, `req[5]` → no `chk_req`, `pos_x` stays 0, return to WAIT in 1 cycle.
- Hard drop from y=23, checker fails at y=17 → `chk_req` held across 7 checks (y 22..16), `pos_y`=17, LOCK entered, `lock_req` high until `lock_done`, then SPAWN.
- After lock, checker returns ok=0 for the spawn → `game_over`=1, state OVER; subsequent `req[0]`/`req[5]` are ignored; `req[1]` recovers.
- Restart pulse mid-CHECK with ack delayed 3 cycles → `chk_req` drops next edge, `clear_req` pulses, a late `chk_ack` is ignored.
